maincontrol: RTL and testbench

Multicycle main controller for the 32-bit MIPS datapath. It decodes the instruction opcode and sequences fetch, decode, execute, memory and writeback through a Moore state machine. It drives all datapath enables and mux selects, and produces the 2-bit `aluop` consumed by `alucontrol`. Memory accesses use a ready handshake, so the FSM stalls on slow memory.

---
 rtl/maincontrol_pkg.sv | 51 +++++
 rtl/maincontrol.sv | 141 ++++++++++++++
 tb/tb_maincontrol.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/maincontrol_pkg.sv
// rtl/maincontrol_pkg.sv - opcodes, aluop codes, state encoding and control word for maincontrol
package maincontrol_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BEQEX    = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JEX      = 4'd11
    } state_t;

    // irwrite/pcen here are the ungated values; the top qualifies them
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsource;
        logic       pcen;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] o);
        return (o == OP_RTYPE) || (o == OP_LB) || (o == OP_SB) ||
               (o == OP_ADDI) || (o == OP_BEQ) || (o == OP_J);
    endfunction

endpackage

// File: rtl/maincontrol.sv
// rtl/maincontrol.sv - multicycle MIPS main controller FSM with memory ready handshake
module maincontrol
    import maincontrol_pkg::*;
#(
    parameter logic WAIT_ON_FETCH = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       pcen,
    output logic       illegal_op
);

    state_t state;
    logic   is_store;
    logic   fetch_done;
    logic   gate;
    ctrl_t  c;

    assign fetch_done = mem_ready | ~WAIT_ON_FETCH;

    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t d;
        d = '0;
        case (s)
            S_FETCH: begin
                d.memread = 1'b1;
                d.alusrcb = 2'b01;
                d.aluop   = ALUOP_ADD;
                d.irwrite = 1'b1;
                d.pcen    = 1'b1;
            end
            S_DECODE: begin
                d.alusrcb = 2'b11;
                d.aluop   = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                d.alusrca = 1'b1;
                d.alusrcb = 2'b10;
                d.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                d.memread = 1'b1;
                d.iord    = 1'b1;
            end
            S_MEMWB: begin
                d.regwrite = 1'b1;
                d.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                d.memwrite = 1'b1;
                d.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                d.alusrca = 1'b1;
                d.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                d.regwrite = 1'b1;
                d.regdst   = 1'b1;
            end
            S_BEQEX: begin
                d.alusrca  = 1'b1;
                d.aluop    = ALUOP_SUB;
                d.pcsource = 2'b01;
                d.pcen     = 1'b1;
            end
            S_ADDIWB: d.regwrite = 1'b1;
            S_JEX: begin
                d.pcsource = 2'b10;
                d.pcen     = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    // lb/sb choice is latched in DECODE because op may change afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            is_store <= 1'b0;
        end else begin
            case (state)
                S_FETCH:   if (fetch_done) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LB:    begin state <= S_MEMADR; is_store <= 1'b0; end
                        OP_SB:    begin state <= S_MEMADR; is_store <= 1'b1; end
                        OP_RTYPE: state <= S_RTYPEEX;
                        OP_BEQ:   state <= S_BEQEX;
                        OP_ADDI:  state <= S_ADDIEX;
                        OP_J:     state <= S_JEX;
                        default:  state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state <= S_FETCH;
                S_RTYPEEX: state <= S_RTYPEWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        c = ctrl_decode(state);
        gate = 1'b1;
        if (state == S_FETCH) gate = fetch_done;
        else if (state == S_BEQEX) gate = zero;
    end

    assign memread    = reset & c.memread;
    assign memwrite   = reset & c.memwrite;
    assign iord       = reset & c.iord;
    assign irwrite    = reset & c.irwrite & gate;
    assign memtoreg   = reset & c.memtoreg;
    assign regdst     = reset & c.regdst;
    assign regwrite   = reset & c.regwrite;
    assign alusrca    = reset & c.alusrca;
    assign alusrcb    = reset ? c.alusrcb : 2'b00;
    assign aluop      = reset ? c.aluop : 2'b00;
    assign pcsource   = reset ? c.pcsource : 2'b00;
    assign pcen       = reset & c.pcen & gate;
    assign illegal_op = reset & (state == S_DECODE) & ~op_supported(op);

endmodule

// File: tb/tb_maincontrol.sv
// tb/tb_maincontrol.sv - self-checking bench for maincontrol
module tb_maincontrol;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsource;
    logic       pcen, illegal_op;

    always #5 clk = ~clk;

    maincontrol dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource), .pcen(pcen),
        .illegal_op(illegal_op)
    );

    wire [15:0] outv = {memread, memwrite, iord, irwrite, memtoreg, regdst, regwrite, alusrca,
                        alusrcb, aluop, pcsource, pcen, illegal_op};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ready;
        logic        z;
        logic [5:0]  op;
        logic [15:0] exp;
        string       tag;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         fst;
        int         mst;
        int         cyc;
    } vec_t;

    cyc_t q[$];
    vec_t tbl[10];

    function automatic logic [15:0] v(input logic mr, mw, io, irw, mtr, rd, rw, asa,
                                      input logic [1:0] asb, aop, pcs,
                                      input logic pe, ill);
        return {mr, mw, io, irw, mtr, rd, rw, asa, asb, aop, pcs, pe, ill};
    endfunction

    function automatic logic legal(input logic [5:0] o);
        return o inside {6'b000000, 6'b100000, 6'b101000, 6'b001000, 6'b000100, 6'b000010};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic [15:0] fetch_stall();
        return v(1,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0, 0);
    endfunction

    task automatic push(input logic r, input logic z, input logic [5:0] o,
                        input logic [15:0] e, input string t);
        cyc_t c;
        c.ready = r; c.z = z; c.op = o; c.exp = e; c.tag = t;
        q.push_back(c);
    endtask

    // expected per-cycle behaviour of one instruction, phase by phase
    task automatic build(input logic [5:0] o, input int fst, input int mst, input logic z);
        for (int i = 0; i < fst; i++) push(1'b0, rb(), rop(), fetch_stall(), "fetch_stall");
        push(1'b1, rb(), rop(), v(1,0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 1, 0), "fetch");
        push(rb(), rb(), o, v(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0, !legal(o)), "decode");
        case (o)
            6'b100000, 6'b101000: begin
                push(rb(), rb(), rop(), v(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 0), "memadr");
                if (o == 6'b100000) begin
                    for (int i = 0; i < mst; i++)
                        push(1'b0, rb(), rop(), v(1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0), "memrd_stall");
                    push(1'b1, rb(), rop(), v(1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0), "memrd");
                    push(rb(), rb(), rop(), v(0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0), "memwb");
                end else begin
                    for (int i = 0; i < mst; i++)
                        push(1'b0, rb(), rop(), v(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0), "memwr_stall");
                    push(1'b1, rb(), rop(), v(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0), "memwr");
                end
            end
            6'b000000: begin
                push(rb(), rb(), rop(), v(0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0, 0), "rtypeex");
                push(rb(), rb(), rop(), v(0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 0, 0), "rtypewb");
            end
            6'b001000: begin
                push(rb(), rb(), rop(), v(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0, 0), "addiex");
                push(rb(), rb(), rop(), v(0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 0, 0), "addiwb");
            end
            6'b000100:
                push(rb(), z, rop(), v(0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, z, 0), "beqex");
            6'b000010:
                push(rb(), rb(), rop(), v(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 1, 0), "jex");
            default: ;
        endcase
    endtask

    task automatic chk(input string t, input logic [15:0] e);
        checks++;
        if (outv !== e) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", t, outv, e, $time);
        end
    endtask

    task automatic step(input cyc_t c);
        mem_ready = c.ready;
        zero = c.z;
        op = c.op;
        #1;
        chk(c.tag, c.exp);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{6'b000000, 1'b0, 0, 0, 4};
        tbl[1] = '{6'b000100, 1'b1, 0, 0, 3};
        tbl[2] = '{6'b000100, 1'b0, 0, 0, 3};
        tbl[3] = '{6'b100000, 1'b0, 0, 2, 7};
        tbl[4] = '{6'b101000, 1'b0, 0, 0, 4};
        tbl[5] = '{6'b000010, 1'b0, 0, 0, 3};
        tbl[6] = '{6'b111111, 1'b0, 0, 0, 2};
        tbl[7] = '{6'b001000, 1'b0, 0, 0, 4};
        tbl[8] = '{6'b100000, 1'b1, 2, 0, 7};
        tbl[9] = '{6'b101000, 1'b0, 1, 1, 6};

        // outputs held at zero through reset regardless of inputs
        mem_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            mem_ready = rb();
            op = rop();
            #1;
            chk("reset_zero", 16'h0000);
            @(negedge clk);
        end
        reset = 1'b1;

        // directed table: run exactly the specified cycle count, then expect FETCH
        for (int n = 0; n < 10; n++) begin
            q.delete();
            build(tbl[n].op, tbl[n].fst, tbl[n].mst, tbl[n].z);
            for (int k = 0; k < tbl[n].cyc; k++) begin
                if (q.size() > 0) step(q.pop_front());
                else begin
                    cyc_t c;
                    c.ready = 1'b0; c.z = 1'b0; c.op = 6'd0; c.exp = fetch_stall(); c.tag = "model_short";
                    step(c);
                end
            end
            mem_ready = 1'b0;
            #1;
            chk("end_in_fetch", fetch_stall());
            @(negedge clk);
        end

        // reset asserted while stalled in MEMWR
        q.delete();
        build(6'b101000, 0, 3, 1'b0);
        for (int k = 0; k < 5; k++) step(q.pop_front());
        q.delete();
        mem_ready = 1'b0;
        #1;
        chk("memwr_stall_pre", v(0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0, 0));
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_memwr", 16'h0000);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("reset_hold", 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("post_reset_fetch", fetch_stall());
        @(negedge clk);

        // randomized instruction stream against the phase model
        for (int n = 0; n < 300; n++) begin
            logic [5:0] o;
            case ($urandom_range(0, 7))
                0: o = 6'b000000;
                1: o = 6'b100000;
                2: o = 6'b101000;
                3: o = 6'b001000;
                4: o = 6'b000100;
                5: o = 6'b000010;
                6: o = rop();
                default: o = 6'b100000;
            endcase
            build(o, $urandom_range(0, 2), $urandom_range(0, 3), rb());
            while (q.size() > 0) step(q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
